// File: rtl/cnn_div_seq_20s_6s_if.sv
// Operand/result handshake bundle for cnn_div_seq_20s_6s.
// The remainder signal exists only when CNN_DIV_REM_EN is defined.
interface cnn_div_seq_20s_6s_if #(
  parameter int DIVIDEND_W = 20,
  parameter int DIVISOR_W  = 6,
  parameter int QUOT_W     = 14
);
  // valid/ready: a transfer happens on a rising clock edge where both valid and ready are high.
  // The producer holds its data stable while valid is high and ready is low.
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DIVIDEND_W-1:0] dividend;
  logic signed [DIVISOR_W-1:0]  divisor;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [QUOT_W-1:0]     quotient;
  logic                         ovf;
  logic                         dz;
`ifdef CNN_DIV_REM_EN
  logic signed [DIVISOR_W-1:0]  remainder;
`endif

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, ovf, dz
`ifdef CNN_DIV_REM_EN
    , input remainder
`endif
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, ovf, dz
`ifdef CNN_DIV_REM_EN
    , output remainder
`endif
  );
endinterface

// File: rtl/cnn_div_seq_20s_6s.sv
// Sequential signed divider: radix-2 restoring on magnitudes, saturating quotient.
// Optional remainder output is enabled by defining CNN_DIV_REM_EN.
module cnn_div_seq_20s_6s #(
  parameter int DIVIDEND_W = 20,
  parameter int DIVISOR_W  = 6,
  parameter int QUOT_W     = 14
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  cnn_div_seq_20s_6s_if.slave   io,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DIVIDEND_W - 1);
  localparam logic [DIVIDEND_W-1:0] POS_LIM  = DIVIDEND_W'((2 ** (QUOT_W - 1)) - 1);
  localparam logic [DIVIDEND_W-1:0] NEG_LIM  = DIVIDEND_W'(2 ** (QUOT_W - 1));
  localparam logic [QUOT_W-1:0]     Q_MAX    = {1'b0, {(QUOT_W-1){1'b1}}};
  localparam logic [QUOT_W-1:0]     Q_MIN    = {1'b1, {(QUOT_W-1){1'b0}}};

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt;
  logic [DIVIDEND_W-1:0]   dq;
  logic [DIVISOR_W:0]      dmag;
  logic [DIVISOR_W-1:0]    rem;
  logic                    q_neg;
  logic                    dvd_neg;
  logic                    dz_q;

  logic                    accept;
  logic                    div_zero;
  logic [DIVIDEND_W-1:0]   dvd_u;
  logic [DIVIDEND_W-1:0]   abs_dvd;
  logic [DIVISOR_W:0]      dvs_x;
  logic [DIVISOR_W:0]      abs_dvs;
  logic [DIVISOR_W:0]      trial;
  logic                    take;
  logic [DIVISOR_W-1:0]    rem_nxt;
  logic [QUOT_W-1:0]       q_res;
  logic                    ovf_res;
  logic                    dz_res;

  assign accept   = io.in_valid && (state_q == IDLE);
  assign div_zero = (io.divisor == '0);

  // Unsigned negation of the most negative dividend yields exactly 2^(W-1), so W bits suffice.
  assign dvd_u   = io.dividend;
  assign abs_dvd = io.dividend[DIVIDEND_W-1] ? (~dvd_u + 1'b1) : dvd_u;
  assign dvs_x   = {io.divisor[DIVISOR_W-1], io.divisor};
  assign abs_dvs = io.divisor[DIVISOR_W-1] ? (~dvs_x + 1'b1) : dvs_x;

  // Partial remainder stays below |divisor| <= 2^(DIVISOR_W-1), so DIVISOR_W bits hold it.
  assign trial   = {rem, dq[DIVIDEND_W-1]};
  assign take    = (trial >= dmag);
  assign rem_nxt = DIVISOR_W'(take ? (trial - dmag) : trial);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (io.in_valid) state_d = div_zero ? FIN : CALC;
      CALC: if (cnt == '0)   state_d = FIN;
      FIN:                   state_d = DONE;
      DONE: if (io.out_ready) state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign dbg_state    = state_q;

  always_comb begin
    q_res   = '0;
    ovf_res = 1'b0;
    dz_res  = 1'b0;
    if (dz_q) begin
      q_res  = dvd_neg ? Q_MIN : Q_MAX;
      dz_res = 1'b1;
    end else if (q_neg) begin
      if (dq > NEG_LIM) begin
        q_res   = Q_MIN;
        ovf_res = 1'b1;
      end else begin
        q_res = ~dq[QUOT_W-1:0] + 1'b1;
      end
    end else begin
      if (dq > POS_LIM) begin
        q_res   = Q_MAX;
        ovf_res = 1'b1;
      end else begin
        q_res = dq[QUOT_W-1:0];
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt         <= '0;
      dq          <= '0;
      dmag        <= '0;
      rem         <= '0;
      q_neg       <= 1'b0;
      dvd_neg     <= 1'b0;
      dz_q        <= 1'b0;
      io.quotient <= '0;
      io.ovf      <= 1'b0;
      io.dz       <= 1'b0;
    end else begin
      if (accept) begin
        cnt     <= CNT_LAST;
        dq      <= abs_dvd;
        dmag    <= abs_dvs;
        rem     <= '0;
        q_neg   <= io.dividend[DIVIDEND_W-1] ^ io.divisor[DIVISOR_W-1];
        dvd_neg <= io.dividend[DIVIDEND_W-1];
        dz_q    <= div_zero;
      end else if (state_q == CALC) begin
        cnt <= cnt - 1'b1;
        dq  <= {dq[DIVIDEND_W-2:0], take};
        rem <= rem_nxt;
      end
      if (state_q == FIN) begin
        io.quotient <= q_res;
        io.ovf      <= ovf_res;
        io.dz       <= dz_res;
      end
    end
  end

`ifdef CNN_DIV_REM_EN
  logic [DIVISOR_W-1:0] r_res;

  // Remainder follows the dividend sign so that q*d + r == dividend.
  always_comb begin
    r_res = '0;
    if (!dz_q) r_res = dvd_neg ? (~rem + 1'b1) : rem;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)             io.remainder <= '0;
    else if (state_q == FIN)   io.remainder <= r_res;
  end
`endif

endmodule

// File: tb/tb_cnn_div_seq_20s_6s.sv
// Directed self-checking bench for cnn_div_seq_20s_6s with hand-computed expected results.
module tb_cnn_div_seq_20s_6s;
  localparam int DW = 20;
  localparam int VW = 6;
  localparam int QW = 14;

  logic       ap_clk = 1'b0;
  logic       ap_rst_n;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  logic [QW+1:0] exp_q[$];

  cnn_div_seq_20s_6s_if #(.DIVIDEND_W(DW), .DIVISOR_W(VW), .QUOT_W(QW)) io ();

  cnn_div_seq_20s_6s #(.DIVIDEND_W(DW), .DIVISOR_W(VW), .QUOT_W(QW)) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .io        (io),
    .dbg_state (dbg_state)
  );

  // clock
  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one operation; returns just after the accepting edge (latency 0 point).
  task automatic send(input logic signed [DW-1:0] a, input logic signed [VW-1:0] b);
    @(negedge ap_clk);
    check("in_ready_before_send", io.in_ready, 1);
    io.in_valid = 1'b1;
    io.dividend = a;
    io.divisor  = b;
    @(negedge ap_clk);
    io.in_valid = 1'b0;
  endtask

  task automatic run_op(input string tag,
                        input logic signed [DW-1:0] a, input logic signed [VW-1:0] b,
                        input logic signed [QW-1:0] eq, input logic e_ovf, input logic e_dz,
                        input logic signed [VW-1:0] er, input int e_lat, input int hold);
    int lat;
    logic [QW+1:0] sb;
    exp_q.push_back({eq, e_ovf, e_dz});
    send(a, b);
    lat = 0;
    while (io.out_valid !== 1'b1 && lat < 200) begin
      @(negedge ap_clk);
      lat++;
    end
    check({tag, "_latency"}, lat, e_lat);
    check({tag, "_quotient"}, $signed(io.quotient), eq);
    check({tag, "_ovf"}, io.ovf, e_ovf);
    check({tag, "_dz"}, io.dz, e_dz);
    check({tag, "_in_ready_done"}, io.in_ready, 0);
`ifdef CNN_DIV_REM_EN
    if (!e_ovf) check({tag, "_remainder"}, $signed(io.remainder), er);
`else
    if (er != 0 && e_ovf) $display("note %s: remainder not checked", tag);
`endif
    if (exp_q.size() > 0) begin
      sb = exp_q.pop_front();
      check({tag, "_scoreboard"}, {io.quotient, io.ovf, io.dz}, sb);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge ap_clk);
      check({tag, "_hold_valid"}, io.out_valid, 1);
      check({tag, "_hold_in_ready"}, io.in_ready, 0);
      check({tag, "_hold_quotient"}, $signed(io.quotient), eq);
      check({tag, "_hold_flags"}, {io.ovf, io.dz}, {e_ovf, e_dz});
    end
    io.out_ready = 1'b1;
    @(negedge ap_clk);
    io.out_ready = 1'b0;
    check({tag, "_valid_after_hs"}, io.out_valid, 0);
    check({tag, "_in_ready_after_hs"}, io.in_ready, 1);
    check({tag, "_quotient_kept"}, $signed(io.quotient), eq);
  endtask

  initial begin
    io.in_valid  = 1'b0;
    io.dividend  = '0;
    io.divisor   = '0;
    io.out_ready = 1'b0;
    ap_rst_n     = 1'b0;
    repeat (3) @(negedge ap_clk);
    check("rst_in_ready", io.in_ready, 1);
    check("rst_out_valid", io.out_valid, 0);
    check("rst_quotient", $signed(io.quotient), 0);
    check("rst_ovf", io.ovf, 0);
    check("rst_dz", io.dz, 0);
    check("rst_state", dbg_state, 0);
    ap_rst_n = 1'b1;

    run_op("p6000_m7",   6000,    -7, -857,  1'b0, 1'b0,  1, 21, 0);
    run_op("m100_p7",    -100,     7, -14,   1'b0, 1'b0, -2, 21, 0);
    run_op("min_m32",    -524288, -32, 8191, 1'b1, 1'b0,  0, 21, 0);
    run_op("max_p1",     524287,   1, 8191,  1'b1, 1'b0,  0, 21, 0);
    run_op("qmin_exact", -253952, 31, -8192, 1'b0, 1'b0,  0, 21, 0);
    run_op("qmax_exact", 24573,    3, 8191,  1'b0, 1'b0,  0, 21, 0);
    run_op("neg_sat",    -16386,   2, -8192, 1'b1, 1'b0,  0, 21, 0);
    run_op("p1000_m32",  1000,   -32, -31,   1'b0, 1'b0,  8, 21, 0);
    run_op("zero_dvd",   0,        5, 0,     1'b0, 1'b0,  0, 21, 0);
    run_op("dz_pos",     123,      0, 8191,  1'b0, 1'b1,  0, 1,  0);
    run_op("dz_neg",     -5,       0, -8192, 1'b0, 1'b1,  0, 1,  0);
    run_op("backpress",  -100,     7, -14,   1'b0, 1'b0, -2, 21, 5);

    // asynchronous reset in the middle of a calculation
    send(6000, -7);
    repeat (9) @(negedge ap_clk);
    check("mid_calc_state", dbg_state, 1);
    ap_rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", io.out_valid, 0);
    check("async_rst_in_ready", io.in_ready, 1);
    check("async_rst_state", dbg_state, 0);
    check("async_rst_quotient", $signed(io.quotient), 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    run_op("after_rst",  40,       8, 5,     1'b0, 1'b0,  0, 21, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
